// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants and the stall-request priority map.
package pipe_ctrl_pkg;

    localparam logic        STOP            = 1'b1;
    localparam logic        NO_STOP         = 1'b0;
    localparam logic        FLUSH           = 1'b1;
    localparam logic        NO_FLUSH        = 1'b0;
    localparam logic        CAUSE_EXCEPTION = 1'b1;
    localparam logic        CAUSE_BRANCH    = 1'b0;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

    localparam logic [3:0]  STALL_NONE      = {NO_STOP, NO_STOP, NO_STOP, NO_STOP};
    localparam logic [3:0]  STALL_FETCH     = {NO_STOP, NO_STOP, NO_STOP, STOP};

    // Deeper stall requests hold every stage in front of them; commit never stops.
    function automatic logic [3:0] stall_map(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [3:0] vec;
        if (req_mem) begin
            vec = {NO_STOP, STOP, STOP, STOP};
        end else if (req_ex || req_id) begin
            vec = {NO_STOP, NO_STOP, STOP, STOP};
        end else if (req_if) begin
            vec = STALL_FETCH;
        end else begin
            vec = STALL_NONE;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: combinational stall vector, exception/branch
// flush with a registered fetch redirect held until fetch accepts it.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        excep_valid_i,
    input  logic [31:0] excep_target_i,
    input  logic        branch_flush_i,
    input  logic [31:0] branch_target_i,
    input  logic        fetch_ready_i,
    output logic [3:0]  stall_o,
    output logic        flush_o,
    output logic        flush_cause_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  stall_s;
    logic        flush_s;
    logic        cause_s;
    logic        branch_ok_s;

    // A branch resolved while execute or memory is stalled is held upstream.
    assign branch_ok_s = branch_flush_i && !stallreq_mem_i && !stallreq_ex_i;

    // Next-state and combinational stall/flush decode.
    always_comb begin
        stall_s  = stall_map(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
        flush_s  = NO_FLUSH;
        cause_s  = CAUSE_BRANCH;
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (excep_valid_i) begin
                    stall_s  = STALL_NONE;
                    flush_s  = FLUSH;
                    cause_s  = CAUSE_EXCEPTION;
                    target_d = excep_target_i;
                    state_d  = ST_REDIRECT;
                end else if (branch_ok_s) begin
                    flush_s  = FLUSH;
                    cause_s  = CAUSE_BRANCH;
                    target_d = branch_target_i;
                    state_d  = ST_REDIRECT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                stall_s = STALL_FETCH;
                if (excep_valid_i) begin
                    flush_s  = FLUSH;
                    cause_s  = CAUSE_EXCEPTION;
                    target_d = excep_target_i;
                    state_d  = ST_REDIRECT;
                end else if (fetch_ready_i && valid_q) begin
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_REDIRECT;
                end
            end
            default: begin
                stall_s  = STALL_NONE;
                state_d  = ST_IDLE;
            end
        endcase
        if (rst) begin
            stall_s = STALL_NONE;
            flush_s = NO_FLUSH;
            cause_s = CAUSE_BRANCH;
        end else begin
            stall_s = stall_s;
        end
        valid_d = (state_d == ST_REDIRECT);
        cnt_d   = (stall_s != STALL_NONE) ? cnt_q + 32'd1 : cnt_q;
    end

    // FSM state, redirect target and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= ZERO_WORD;
            valid_q  <= 1'b0;
            cnt_q    <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stall_o          = stall_s;
    assign flush_o          = flush_s;
    assign flush_cause_o    = cause_s;
    assign redirect_valid_o = valid_q;
    assign redirect_pc_o    = target_q;
    assign stall_cnt_o      = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: decode table, directed corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_if, s_id, s_ex, s_mem;
    logic        exc;
    logic [31:0] exc_t;
    logic        br;
    logic [31:0] br_t;
    logic        fr;
    logic [3:0]  stall_o;
    logic        flush_o, cause_o, rv_o;
    logic [31:0] rpc_o, cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit          m_redir;
    logic [31:0] m_target;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_if_i(s_if), .stallreq_id_i(s_id),
        .stallreq_ex_i(s_ex), .stallreq_mem_i(s_mem),
        .excep_valid_i(exc), .excep_target_i(exc_t),
        .branch_flush_i(br), .branch_target_i(br_t),
        .fetch_ready_i(fr),
        .stall_o(stall_o), .flush_o(flush_o), .flush_cause_o(cause_o),
        .redirect_valid_o(rv_o), .redirect_pc_o(rpc_o), .stall_cnt_o(cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected combinational outputs from the model for the current inputs
    task automatic model_comb(output logic [3:0] e_stall, output logic e_flush, output logic e_cause);
        e_stall = 4'd0; e_flush = 1'b0; e_cause = 1'b0;
        if (rst) begin
            e_stall = 4'd0;
        end else if (m_redir) begin
            e_stall = 4'b0001;
            if (exc) begin e_flush = 1'b1; e_cause = 1'b1; end
        end else if (exc) begin
            e_flush = 1'b1; e_cause = 1'b1;
        end else begin
            e_stall = s_mem ? 4'b0111 : (s_ex || s_id) ? 4'b0011 : s_if ? 4'b0001 : 4'b0000;
            if (br && !s_mem && !s_ex) begin e_flush = 1'b1; e_cause = 1'b0; end
        end
    endtask

    // drive one cycle of inputs and compare mid-cycle against the model
    task automatic step(input logic r, input logic [3:0] req, input logic e, input logic [31:0] et,
                        input logic b, input logic [31:0] bt, input logic f);
        logic [3:0] es; logic ef, ec;
        rst = r; s_if = req[0]; s_id = req[1]; s_ex = req[2]; s_mem = req[3];
        exc = e; exc_t = et; br = b; br_t = bt; fr = f;
        #3;
        model_comb(es, ef, ec);
        check("model_stall", {28'd0, stall_o}, {28'd0, es});
        check("model_flush", {31'd0, flush_o}, {31'd0, ef});
        check("model_cause", {31'd0, cause_o}, {31'd0, ec});
        check("model_rvalid", {31'd0, rv_o}, {31'd0, m_redir});
        check("model_rpc", rpc_o, m_target);
        check("model_cnt", cnt_o, m_cnt);
    endtask

    // advance to the next edge and update the model with the inputs of this cycle
    task automatic tick();
        logic [3:0] es; logic ef, ec;
        model_comb(es, ef, ec);
        @(posedge clk);
        if (rst) begin
            m_redir = 1'b0; m_target = 32'd0; m_cnt = 32'd0;
        end else begin
            if (es != 4'd0) m_cnt = m_cnt + 32'd1;
            if (m_redir) begin
                if (exc) m_target = exc_t;
                else if (fr) m_redir = 1'b0;
            end else if (exc) begin
                m_redir = 1'b1; m_target = exc_t;
            end else if (br && !s_mem && !s_ex) begin
                m_redir = 1'b1; m_target = br_t;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 4'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
    endtask

    typedef struct packed {
        logic [3:0] req;   // {mem, ex, id, if}
        logic       e;
        logic       b;
        logic [3:0] x_stall;
        logic       x_flush;
        logic       x_cause;
    } vec_t;

    vec_t tbl [13];

    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;
    localparam logic [31:0] BR_PC  = 32'h8000_1000;

    initial begin
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0};
        tbl[3]  = '{4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0};
        tbl[4]  = '{4'b0100, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0};
        tbl[5]  = '{4'b0110, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0};
        tbl[6]  = '{4'b1000, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
        tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
        tbl[8]  = '{4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[10] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0};
        tbl[11] = '{4'b1000, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1};

        rst = 1'b1; s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0; s_mem = 1'b0;
        exc = 1'b0; exc_t = 32'd0; br = 1'b0; br_t = 32'd0; fr = 1'b0;
        @(posedge clk); #1;
        m_redir = 1'b0; m_target = 32'd0; m_cnt = 32'd0;

        // reset state, with inputs active during reset
        step(1'b1, 4'b1111, 1'b1, EXC_PC, 1'b1, BR_PC, 1'b1);
        check("rst_stall", {28'd0, stall_o}, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        tick();
        check("rst_rvalid", {31'd0, rv_o}, 32'd0);
        check("rst_rpc", rpc_o, 32'd0);
        check("rst_cnt", cnt_o, 32'd0);

        // decode table from IDLE
        for (int i = 0; i < 13; i++) begin
            do_reset();
            step(1'b0, tbl[i].req, tbl[i].e, EXC_PC, tbl[i].b, BR_PC, 1'b0);
            check($sformatf("tbl%0d_stall", i), {28'd0, stall_o}, {28'd0, tbl[i].x_stall});
            check($sformatf("tbl%0d_flush", i), {31'd0, flush_o}, {31'd0, tbl[i].x_flush});
            check($sformatf("tbl%0d_cause", i), {31'd0, cause_o}, {31'd0, tbl[i].x_cause});
            tick();
        end

        // mem stall for three cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            check("mem3_stall", {28'd0, stall_o}, 32'h7);
            tick();
        end
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check("mem3_cnt", cnt_o, 32'd3);
        tick();

        // exception, then redirect
        do_reset();
        step(1'b0, 4'b0000, 1'b1, EXC_PC, 1'b0, 32'd0, 1'b0);
        check("exc_flush", {31'd0, flush_o}, 32'd1);
        check("exc_cause", {31'd0, cause_o}, 32'd1);
        tick();
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check("exc_rvalid", {31'd0, rv_o}, 32'd1);
        check("exc_rpc", rpc_o, EXC_PC);
        check("exc_rstall", {28'd0, stall_o}, 32'h1);
        tick();

        // exception and branch together
        do_reset();
        step(1'b0, 4'b0000, 1'b1, EXC_PC, 1'b1, BR_PC, 1'b0);
        check("both_cause", {31'd0, cause_o}, 32'd1);
        tick();
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check("both_rpc", rpc_o, EXC_PC);
        tick();

        // redirect held while fetch not ready
        do_reset();
        step(1'b0, 4'b0000, 1'b1, EXC_PC, 1'b0, 32'd0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0, (i == 4) ? 1'b1 : 1'b0);
            check("hold_rvalid", {31'd0, rv_o}, 32'd1);
            tick();
        end
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check("hold_idle", {31'd0, rv_o}, 32'd0);
        check("hold_idle_stall", {28'd0, stall_o}, 32'd0);
        tick();

        // branch held behind execute stall
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b0100, 1'b0, 32'd0, 1'b1, BR_PC, 1'b0);
            check("brex_noflush", {31'd0, flush_o}, 32'd0);
            tick();
        end
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b1, BR_PC, 1'b0);
        check("brex_flush", {31'd0, flush_o}, 32'd1);
        check("brex_cause", {31'd0, cause_o}, 32'd0);
        tick();
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check("brex_rpc", rpc_o, BR_PC);
        tick();

        // reset in the middle of a redirect
        do_reset();
        step(1'b0, 4'b1000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        step(1'b0, 4'b0000, 1'b1, EXC_PC, 1'b0, 32'd0, 1'b0);
        tick();
        step(1'b1, 4'b0000, 1'b1, EXC_PC, 1'b0, 32'd0, 1'b0);
        check("midrst_flush", {31'd0, flush_o}, 32'd0);
        tick();
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check("midrst_rvalid", {31'd0, rv_o}, 32'd0);
        check("midrst_cnt", cnt_o, 32'd0);
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, $urandom,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, $urandom,
                 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
